// File: rtl/sdram_rd_pkg.sv
// Shared state encoding and default widths for the SDRAM read-side sequencer.
package sdram_rd_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4
  } rd_state_e;

endpackage

// File: rtl/sdram_rd_fifo.sv
// Synchronous show-ahead FIFO with a registered head word and occupancy count.
module sdram_rd_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [LVL_W-1:0]  level
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic [LVL_W-1:0]  level_next_s;
  logic [DATA_W-1:0] head_next_s;

  // Next occupancy and next head word
  always_comb begin
    push_ok_s    = push && (level != FULL_LVL);
    pop_ok_s     = pop && valid;
    level_next_s = level;
    head_next_s  = head;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_next_s = level + ONE_LVL;
      2'b01:   level_next_s = level - ONE_LVL;
      default: level_next_s = level;
    endcase
    // A pop exposes the next stored word, or the word arriving this cycle if none is stored
    if (pop_ok_s) begin
      if (level > ONE_LVL) begin
        head_next_s = mem_r[rd_ptr_r + PTR_W'(1)];
      end else if (push_ok_s) begin
        head_next_s = push_data;
      end else begin
        head_next_s = head;
      end
    end else if (push_ok_s && !valid) begin
      head_next_s = push_data;
    end else begin
      head_next_s = head;
    end
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level    <= '0;
      valid    <= 1'b0;
      head     <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level <= level_next_s;
      valid <= (level_next_s != '0);
      head  <= head_next_s;
    end
  end

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/sdram_burst_reader.sv
// Burst read sequencer: one edge-triggered read handshake per word into a show-ahead FIFO.
module sdram_burst_reader
  import sdram_rd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = 16,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_req,
  input  logic              mem_read_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  rd_state_e         state_r;
  rd_state_e         state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_next_s;
  logic [ADDR_W-1:0] mem_address_next_s;
  logic [LEN_W-1:0]  rem_r;
  logic [LEN_W-1:0]  rem_next_s;
  logic              abort_lat_r;
  logic              abort_next_s;
  logic              req_next_s;
  logic              push_s;

  // Next-state, counter and request decode
  always_comb begin
    state_next_s       = state_r;
    addr_next_s        = addr_r;
    rem_next_s         = rem_r;
    abort_next_s       = abort_lat_r;
    req_next_s         = mem_read_req;
    mem_address_next_s = mem_address;
    push_s             = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          abort_next_s = 1'b0;
          if (length != '0) begin
            addr_next_s  = start_addr;
            rem_next_s   = length;
            state_next_s = ISSUE;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_next_s = DONE;
        end else if (fifo_level < FULL_LVL) begin
          req_next_s         = 1'b1;
          mem_address_next_s = addr_r;
          state_next_s       = WAIT_ACK;
        end else begin
          req_next_s = 1'b0;
        end
      end
      WAIT_ACK: begin
        // The request is never withdrawn early; abort only stops the next one
        if (abort) abort_next_s = 1'b1;
        else       abort_next_s = abort_lat_r;
        if (mem_read_ack) begin
          push_s       = 1'b1;
          req_next_s   = 1'b0;
          addr_next_s  = addr_r + ADDR_W'(1);
          rem_next_s   = rem_r - LEN_W'(1);
          state_next_s = GAP;
        end else begin
          req_next_s = 1'b1;
        end
      end
      GAP: begin
        if (abort) abort_next_s = 1'b1;
        else       abort_next_s = abort_lat_r;
        if (!mem_read_ack) begin
          if ((rem_r == '0) || abort_lat_r || abort) state_next_s = DONE;
          else                                       state_next_s = ISSUE;
        end else begin
          state_next_s = GAP;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, counters and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_r      <= IDLE;
      addr_r       <= '0;
      rem_r        <= '0;
      abort_lat_r  <= 1'b0;
      mem_address  <= '0;
      mem_read_req <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      addr_r       <= addr_next_s;
      rem_r        <= rem_next_s;
      abort_lat_r  <= abort_next_s;
      mem_address  <= mem_address_next_s;
      mem_read_req <= req_next_s;
      busy         <= (state_r != IDLE);
      done         <= (state_r == DONE);
    end
  end

  sdram_rd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .push      (push_s),
    .push_data (mem_data),
    .pop       (out_ready),
    .head      (out_data),
    .valid     (out_valid),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Scoreboard bench for sdram_burst_reader with a fixed-latency read-ack responder.
module tb_sdram_burst_reader;

  localparam int ACK_LAT = 3;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [23:0] start_addr;
  logic [15:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic [23:0] mem_address;
  logic        mem_read_req;
  logic        mem_read_ack;
  logic [15:0] mem_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fifo_level;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  int ack_cnt = 0;
  logic [15:0] exp_data_q[$];
  logic [23:0] exp_addr_q[$];
  logic        req_prev = 1'b0;
  logic [23:0] held_addr = 24'h000000;
  logic        resp_en = 1'b1;
  logic        manual_ack = 1'b0;

  always #5 clk = ~clk;

  sdram_burst_reader dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .start_addr   (start_addr),
    .length       (length),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .mem_address  (mem_address),
    .mem_read_req (mem_read_req),
    .mem_read_ack (mem_read_ack),
    .mem_data     (mem_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_level   (fifo_level)
  );

  function automatic logic [15:0] dfun(input logic [23:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic launch(input logic [23:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; length = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wrapper model: ack for one cycle after ACK_LAT cycles of request, or manual drive
  initial begin : responder
    int lat;
    lat = 0;
    mem_read_ack = 1'b0;
    mem_data = 16'h0000;
    forever begin
      @(posedge clk); #2;
      if (!resp_en) begin
        mem_read_ack = manual_ack;
        mem_data = 16'hDEAD;
        lat = 0;
      end else begin
        mem_read_ack = 1'b0;
        if (mem_read_req) begin
          if (lat == ACK_LAT - 1) begin
            mem_read_ack = 1'b1;
            mem_data = dfun(mem_address);
            lat = 0;
          end else begin
            lat++;
          end
        end else begin
          lat = 0;
        end
      end
    end
  end

  // Monitor: pops scoreboards on output beats and request edges
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_word: got %0h required none", out_data);
        end else begin
          chk("out_data", {16'b0, out_data}, {16'b0, exp_data_q.pop_front()});
        end
      end
      if (mem_read_req && !req_prev) begin
        rise_cnt++;
        held_addr = mem_address;
        if (exp_addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_req: got addr %0h required none", mem_address);
        end else begin
          chk("req_addr", {8'b0, mem_address}, {8'b0, exp_addr_q.pop_front()});
        end
      end
      if (mem_read_req && mem_read_ack) begin
        ack_cnt++;
        chk("addr_held", {8'b0, mem_address}, {8'b0, held_addr});
      end
      if (done) done_cnt++;
      req_prev = mem_read_req;
    end
  end

  initial begin : main
    int base_ack, base_rise, base_done, i;
    sys_rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_addr = 24'h000000; length = 16'h0000; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_req", {31'b0, mem_read_req}, 32'd0);
    chk("rst_addr", {8'b0, mem_address}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", {16'b0, out_data}, 32'd0);
    chk("rst_level", {27'b0, fifo_level}, 32'd0);
    sys_rst = 1'b0;

    // Basic 4-word fetch, with a start pulse while busy
    base_done = done_cnt;
    exp_addr_q.push_back(24'h000100); exp_addr_q.push_back(24'h000101);
    exp_addr_q.push_back(24'h000102); exp_addr_q.push_back(24'h000103);
    exp_data_q.push_back(16'h00FF); exp_data_q.push_back(16'h01FE);
    exp_data_q.push_back(16'h02FD); exp_data_q.push_back(16'h03FC);
    launch(24'h000100, 16'd4);
    @(negedge clk); chk("lat_c1_req", {31'b0, mem_read_req}, 32'd0);
    @(negedge clk); chk("lat_c2_req", {31'b0, mem_read_req}, 32'd1);
    launch(24'h000555, 16'd7);
    wait_done(200);
    repeat (2) tick();
    chk("basic_busy_low", {31'b0, busy}, 32'd0);
    chk("basic_one_done", done_cnt - base_done, 32'd1);
    chk("basic_words", exp_data_q.size(), 32'd0);
    chk("basic_addrs", exp_addr_q.size(), 32'd0);

    // Zero length: done at cycle 2, no request
    base_rise = rise_cnt;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 24'h00ABCD; length = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); chk("len0_c1_done", {31'b0, done}, 32'd0);
    @(negedge clk); chk("len0_c2_done", {31'b0, done}, 32'd1);
    repeat (3) tick();
    chk("len0_no_req", rise_cnt - base_rise, 32'd0);
    chk("len0_busy_low", {31'b0, busy}, 32'd0);

    // Backpressure: 20 words with out_ready low, FIFO fills to 16 and stalls
    out_ready = 1'b0;
    base_ack = ack_cnt;
    for (int k = 0; k < 20; k++) begin
      exp_addr_q.push_back(24'(24'h002000 + k));
      exp_data_q.push_back(dfun(24'(24'h002000 + k)));
    end
    launch(24'h002000, 16'd20);
    i = 0;
    while (fifo_level != 5'd16 && i < 500) begin tick(); i++; end
    repeat (20) tick();
    chk("bp_level", {27'b0, fifo_level}, 32'd16);
    chk("bp_pushes", ack_cnt - base_ack, 32'd16);
    chk("bp_req_low", {31'b0, mem_read_req}, 32'd0);
    chk("bp_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(600);
    repeat (3) tick();
    chk("bp_total", ack_cnt - base_ack, 32'd20);
    chk("bp_drained", exp_data_q.size(), 32'd0);
    chk("bp_level_end", {27'b0, fifo_level}, 32'd0);

    // Address wrap at the top of the address space
    exp_addr_q.push_back(24'hFFFFFE); exp_addr_q.push_back(24'hFFFFFF);
    exp_addr_q.push_back(24'h000000);
    exp_data_q.push_back(16'hFE01); exp_data_q.push_back(16'hFF00);
    exp_data_q.push_back(16'h00FF);
    launch(24'hFFFFFE, 16'd3);
    wait_done(200);
    repeat (2) tick();
    chk("wrap_words", exp_data_q.size(), 32'd0);
    chk("wrap_addrs", exp_addr_q.size(), 32'd0);

    // Abort while word 2 of 10 is in flight
    out_ready = 1'b0;
    base_rise = rise_cnt; base_done = done_cnt;
    for (int k = 0; k < 3; k++) begin
      exp_addr_q.push_back(24'(24'h003000 + k));
      exp_data_q.push_back(dfun(24'(24'h003000 + k)));
    end
    launch(24'h003000, 16'd10);
    i = 0;
    while ((rise_cnt - base_rise) < 3 && i < 300) begin tick(); i++; end
    chk("abort_reach_w2", rise_cnt - base_rise, 32'd3);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk); chk("abort_req_held", {31'b0, mem_read_req}, 32'd1);
    wait_done(100);
    repeat (5) tick();
    chk("abort_level", {27'b0, fifo_level}, 32'd3);
    chk("abort_no_w3", rise_cnt - base_rise, 32'd3);
    chk("abort_one_done", done_cnt - base_done, 32'd1);
    chk("abort_busy_low", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("abort_drained", exp_data_q.size(), 32'd0);

    // Reset during WAIT_ACK followed by a late ack
    resp_en = 1'b0; manual_ack = 1'b0;
    base_rise = rise_cnt;
    exp_addr_q.push_back(24'h004000);
    launch(24'h004000, 16'd2);
    i = 0;
    while (mem_read_req !== 1'b1 && i < 20) begin tick(); i++; end
    chk("rst_wait_req", {31'b0, mem_read_req}, 32'd1);
    @(posedge clk); #1; sys_rst = 1'b1;
    @(posedge clk); #1; sys_rst = 1'b0; manual_ack = 1'b1;
    @(negedge clk);
    chk("rstw_req", {31'b0, mem_read_req}, 32'd0);
    chk("rstw_level", {27'b0, fifo_level}, 32'd0);
    chk("rstw_busy", {31'b0, busy}, 32'd0);
    repeat (3) tick();
    chk("rstw_late_ack", {27'b0, fifo_level}, 32'd0);
    chk("rstw_valid", {31'b0, out_valid}, 32'd0);
    chk("rstw_idle", {31'b0, busy}, 32'd0);
    chk("rstw_no_req", rise_cnt - base_rise, 32'd1);
    @(posedge clk); #1;
    manual_ack = 1'b0; resp_en = 1'b1;
    repeat (3) tick();

    chk("final_addr_q", exp_addr_q.size(), 32'd0);
    chk("final_data_q", exp_data_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
